// File: rtl/ksa_pkg.sv
// Shared definitions for the RC4 loop stages: PRGA state encoding and
// the plaintext character set used to judge a decryption attempt.
package ksa_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ISSUE_I,
    ST_LATCH_I,
    ST_ISSUE_J,
    ST_LATCH_J,
    ST_WRITE_I,
    ST_WRITE_J,
    ST_ISSUE_F,
    ST_LATCH_F,
    ST_WRITE_OUT,
    ST_DONE
  } prga_state_t;

  // A plaintext byte is acceptable if it is a space or a lowercase letter.
  function automatic logic is_text_char(input logic [7:0] value);
    return (value == CHAR_SPACE) || ((value >= CHAR_A) && (value <= CHAR_Z));
  endfunction

endpackage

// File: rtl/char_checker.sv
// Combinational plaintext filter: flags whether a decrypted byte lies in
// the expected character set. Shared with the key-search controller.
module char_checker
  import ksa_pkg::*;
(
  input  logic [7:0] data_in,
  output logic       valid
);

  // Pure lookup against the accepted character set.
  always_comb begin
    valid = is_text_char(data_in);
  end

endmodule

// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation stage. Walks the keyed S array, swaps
// S[i]/S[j], reads the keystream byte S[S[i]+S[j]], XORs it with the
// encrypted ROM byte and writes plaintext to the output RAM. Nine cycles
// per byte; all memories have a one-cycle registered read.
module prga_decrypt
  import ksa_pkg::*;
#(
  parameter int MSG_LEN  = MSG_LEN_DEFAULT,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_flag,
  output logic       done_flag,
  output logic       bad_flag,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  input  logic [7:0] s_data_read,
  output logic       s_wren,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] out_address,
  output logic [7:0] out_data,
  output logic       out_wren
);

  // Index of the final message byte; k is 8 bits so 256 bytes wraps to 255.
  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  prga_state_t state_reg, state_next;

  logic [7:0] i_reg,   i_next;
  logic [7:0] j_reg,   j_next;
  logic [7:0] k_reg,   k_next;
  logic [7:0] si_reg,  si_next;
  logic [7:0] sj_reg,  sj_next;
  logic [7:0] f_reg,   f_next;
  logic [7:0] enc_reg, enc_next;
  logic       bad_reg, bad_next;

  logic [7:0] plain_byte;
  logic       plain_valid;

  assign plain_byte = f_reg ^ enc_reg;

  char_checker u_char_checker (
    .data_in (plain_byte),
    .valid   (plain_valid)
  );

  // State and datapath registers; reset clears everything so every output
  // decodes to zero while in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      i_reg     <= 8'd0;
      j_reg     <= 8'd0;
      k_reg     <= 8'd0;
      si_reg    <= 8'd0;
      sj_reg    <= 8'd0;
      f_reg     <= 8'd0;
      enc_reg   <= 8'd0;
      bad_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      si_reg    <= si_next;
      sj_reg    <= sj_next;
      f_reg     <= f_next;
      enc_reg   <= enc_next;
      bad_reg   <= bad_next;
    end
  end

  // Next-state and register updates. Data is captured in the LATCH_x state
  // that follows the ISSUE_x state which drove the address.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    f_next     = f_reg;
    enc_next   = enc_reg;
    bad_next   = bad_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_flag) begin
          i_next     = 8'd1;
          j_next     = 8'd0;
          k_next     = 8'd0;
          bad_next   = 1'b0;
          state_next = ST_ISSUE_I;
        end
      end
      ST_ISSUE_I: state_next = ST_LATCH_I;
      ST_LATCH_I: begin
        si_next    = s_data_read;
        enc_next   = rom_q;
        j_next     = j_reg + s_data_read;
        state_next = ST_ISSUE_J;
      end
      ST_ISSUE_J: state_next = ST_LATCH_J;
      ST_LATCH_J: begin
        sj_next    = s_data_read;
        state_next = ST_WRITE_I;
      end
      ST_WRITE_I: state_next = ST_WRITE_J;
      ST_WRITE_J: state_next = ST_ISSUE_F;
      ST_ISSUE_F: state_next = ST_LATCH_F;
      ST_LATCH_F: begin
        f_next     = s_data_read;
        state_next = ST_WRITE_OUT;
      end
      ST_WRITE_OUT: begin
        // The byte is written regardless; an invalid byte only ends the run.
        if (CHECK_EN && !plain_valid) begin
          bad_next   = 1'b1;
          state_next = ST_DONE;
        end else if (k_reg == LAST_K) begin
          state_next = ST_DONE;
        end else begin
          k_next     = k_reg + 8'd1;
          i_next     = i_reg + 8'd1;
          state_next = ST_ISSUE_I;
        end
      end
      ST_DONE: begin
        if (!start_flag) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory-port and handshake outputs decoded from the current state;
  // everything not listed for a state stays at zero.
  always_comb begin
    s_address   = 8'd0;
    s_data      = 8'd0;
    s_wren      = 1'b0;
    rom_address = 8'd0;
    out_address = 8'd0;
    out_data    = 8'd0;
    out_wren    = 1'b0;
    done_flag   = 1'b0;
    case (state_reg)
      ST_ISSUE_I: begin
        s_address   = i_reg;
        rom_address = k_reg;
      end
      ST_ISSUE_J: s_address = j_reg;
      ST_WRITE_I: begin
        s_address = i_reg;
        s_data    = sj_reg;
        s_wren    = 1'b1;
      end
      ST_WRITE_J: begin
        s_address = j_reg;
        s_data    = si_reg;
        s_wren    = 1'b1;
      end
      ST_ISSUE_F: s_address = si_reg + sj_reg;
      ST_WRITE_OUT: begin
        out_address = k_reg;
        out_data    = plain_byte;
        out_wren    = 1'b1;
      end
      ST_DONE: done_flag = 1'b1;
      default: ;
    endcase
  end

  assign bad_flag = bad_reg;

endmodule
